// File: rtl/sign_mag_decoder.sv
// Serial two's-complement to sign/magnitude converter, one bit per cycle, LSB first.
// Optional macro SIGN_MAG_FAST_POS_EN: non-negative operands bypass the serial pass.
module sign_mag_decoder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_mag;
  logic [CW-1:0]    r_cnt;
  logic             r_seen_one;
  logic             r_sign;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_out_bit;
  logic             w_fast_next;

  // Once the first 1 has passed, remaining bits of a negative operand invert.
  function automatic logic conv_bit(input logic s, input logic seen, input logic b);
    conv_bit = (s & seen) ? ~b : b;
  endfunction

`ifdef SIGN_MAG_FAST_POS_EN
  logic r_fast;
`endif

  // Next-state decode, start acceptance and fast-path tracking.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_fast_next = 1'b0;
    w_out_bit   = conv_bit(r_sign, r_seen_one, r_shift[0]);
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
`ifdef SIGN_MAG_FAST_POS_EN
    if (w_accept) begin
      w_fast_next = ~in_data[WIDTH-1];
    end else if (r_state == RUN) begin
      w_fast_next = r_fast;
    end else begin
      w_fast_next = 1'b0;
    end
`endif
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN) && !w_fast_next;
      r_done  <= (w_next == DONE);
    end
  end

  // Operand latch, serial conversion datapath and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= {WIDTH{1'b0}};
      r_mag      <= {WIDTH{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_seen_one <= 1'b0;
      r_sign     <= 1'b0;
    end else if (w_accept) begin
      r_shift    <= in_data;
      r_sign     <= in_data[WIDTH-1];
      r_seen_one <= 1'b0;
`ifdef SIGN_MAG_FAST_POS_EN
      // A positive operand is already its own magnitude; park the counter at
      // its terminal value so the single RUN cycle falls straight into DONE.
      if (!in_data[WIDTH-1]) begin
        r_mag <= in_data;
        r_cnt <= LAST_CNT;
      end else begin
        r_cnt <= {CW{1'b0}};
      end
`else
      r_cnt <= {CW{1'b0}};
`endif
    end else if (r_state == RUN) begin
`ifdef SIGN_MAG_FAST_POS_EN
      if (!r_fast) begin
        r_shift    <= r_shift >> 1;
        r_mag      <= {w_out_bit, r_mag[WIDTH-1:1]};
        r_seen_one <= r_seen_one | r_shift[0];
      end
`else
      r_shift    <= r_shift >> 1;
      r_mag      <= {w_out_bit, r_mag[WIDTH-1:1]};
      r_seen_one <= r_seen_one | r_shift[0];
`endif
      if (r_cnt != LAST_CNT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef SIGN_MAG_FAST_POS_EN
  // Marks a conversion taking the positive-operand bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fast <= 1'b0;
    end else begin
      r_fast <= w_fast_next;
    end
  end
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign sign = r_sign;
  assign mag  = r_mag;

endmodule
